// File: rtl/dbus_hs_pkg.sv
// Shared definitions for the handshaked data-bus interconnect: default bus geometry,
// FSM state encodings and a small state helper used by the top.
package dbus_hs_pkg;

  localparam int DEF_DW  = 16;
  localparam int DEF_AW  = 16;
  localparam int DEF_BSW = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // True for the two states that drive the one-cycle response strobe.
  function automatic logic is_resp_state(input state_t st);
    return (st == ST_RESP) || (st == ST_ERR);
  endfunction

endpackage

// File: rtl/dbus_hs_if.sv
// Bus bundle between the core, the interconnect and its slaves. Modports are named
// after the side of the interconnect they face: master = core side, slave = slave side.
interface dbus_hs_if
  import dbus_hs_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int BSW  = DEF_BSW,
  parameter int NSLV = 2
);

  logic                m_req;
  logic                m_we;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_din;
  logic                m_gnt;
  logic                m_rvalid;
  logic [DW-1:0]       m_dout;
  logic                m_err;

  logic [NSLV-1:0]     s_sel;
  logic                s_we;
  logic [AW-BSW-1:0]   s_addr;
  logic [DW-1:0]       s_din;
  logic [NSLV-1:0]     s_ack;
  logic [NSLV*DW-1:0]  s_dout;

  modport master (
    input  m_req, m_we, m_addr, m_din,
    output m_gnt, m_rvalid, m_dout, m_err
  );

  modport slave (
    output s_sel, s_we, s_addr, s_din,
    input  s_ack, s_dout
  );

endinterface

// File: rtl/dbus_hs_tmo.sv
// Wait-state watchdog: counts BUSY cycles and flags the cycle whose edge would
// bring the count to TMO_MAX. TMO_MAX = 0 disables the expiry output entirely.
module dbus_hs_tmo #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_r;

  // Cycle counter: cleared on entry to BUSY, advances while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = en && (TMO_MAX != 0) && (cnt_r == TMO_W'(TMO_MAX - 1));

endmodule

// File: rtl/dbus_hs.sv
// One-master, NSLV-region data-bus interconnect with slave wait states, unmapped-region
// errors and a bounded ack timeout. One access in flight; responses are one-cycle strobes.
module dbus_hs
  import dbus_hs_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int BSW     = DEF_BSW,
  parameter int NSLV    = 2,
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
)(
  input  logic      clk,
  input  logic      rst,
  dbus_hs_if.master mif,
  dbus_hs_if.slave  sif
);

  localparam int OW = AW - BSW;

  state_t          state_r;
  state_t          state_nx_s;
  logic [BSW-1:0]  region_s;
  logic            mapped_s;
  logic            accept_s;
  logic            ack_s;
  logic            tmo_exp_s;
  logic            leave_busy_s;
  logic [NSLV-1:0] onehot_s;
  logic [DW-1:0]   rdata_s;

  logic [NSLV-1:0] sel_r;
  logic            we_r;
  logic [OW-1:0]   addr_r;
  logic [DW-1:0]   din_r;
  logic            rvalid_r;
  logic            err_r;
  logic [DW-1:0]   dout_r;

  assign region_s     = mif.m_addr[AW-1 -: BSW];
  assign mapped_s     = int'(region_s) < NSLV;
  assign accept_s     = (state_r == ST_IDLE) && mif.m_req;
  // Masking with the registered select drops acks from every non-selected slave.
  assign ack_s        = (state_r == ST_BUSY) && (|(sif.s_ack & sel_r));
  assign leave_busy_s = (state_r == ST_BUSY) && (state_nx_s != ST_BUSY);

  // Region decode to a one-hot select.
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      onehot_s[i] = (int'(region_s) == i);
    end
  end

  // Read-data mux driven by the registered select.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      rdata_s = rdata_s | ({DW{sel_r[i]}} & sif.s_dout[i*DW +: DW]);
    end
  end

  // Next-state logic; ack is tested before the timeout so it wins a tie.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mif.m_req) begin
          state_nx_s = mapped_s ? ST_BUSY : ST_ERR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack_s) begin
          state_nx_s = ST_RESP;
        end else if (tmo_exp_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, request register and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sel_r    <= '0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      din_r    <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      dout_r   <= '0;
    end else begin
      state_r  <= state_nx_s;
      rvalid_r <= is_resp_state(state_nx_s);
      err_r    <= (state_nx_s == ST_ERR);
      if (accept_s) begin
        sel_r  <= mapped_s ? onehot_s : '0;
        we_r   <= mapped_s && mif.m_we;
        addr_r <= mif.m_addr[OW-1:0];
        din_r  <= mif.m_din;
      end else if (leave_busy_s) begin
        sel_r  <= '0;
        we_r   <= 1'b0;
      end else begin
        sel_r  <= sel_r;
        we_r   <= we_r;
      end
      if (ack_s) begin
        dout_r <= we_r ? '0 : rdata_s;
      end else if (state_nx_s == ST_ERR) begin
        dout_r <= '0;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  dbus_hs_tmo #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_s && mapped_s),
    .en      (state_r == ST_BUSY),
    .expired (tmo_exp_s)
  );

  assign mif.m_gnt    = (state_r == ST_IDLE);
  assign mif.m_rvalid = rvalid_r;
  assign mif.m_err    = err_r;
  assign mif.m_dout   = dout_r;
  assign sif.s_sel    = sel_r;
  assign sif.s_we     = we_r;
  assign sif.s_addr   = addr_r;
  assign sif.s_din    = din_r;

endmodule

// File: tb/tb_dbus_hs.sv
// Directed bench for dbus_hs: hand-driven slave acks and hand-computed expected responses.
module tb_dbus_hs;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int BSW     = 3;
  localparam int NSLV    = 2;
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  dbus_hs_if #(.DW(DW), .AW(AW), .BSW(BSW), .NSLV(NSLV)) bus ();

  dbus_hs #(
    .DW(DW), .AW(AW), .BSW(BSW), .NSLV(NSLV), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mif (bus),
    .sif (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] din);
    bus.m_req  = 1'b1;
    bus.m_we   = we;
    bus.m_addr = addr;
    bus.m_din  = din;
  endtask

  task automatic resp_chk(input string tag, input logic err, input logic [15:0] dout);
    chk({tag, "_rvalid"}, 32'(bus.m_rvalid), 32'd1);
    chk({tag, "_err"},    32'(bus.m_err),    32'(err));
    chk({tag, "_dout"},   32'(bus.m_dout),   32'(dout));
    chk({tag, "_sel"},    32'(bus.s_sel),    32'd0);
    chk({tag, "_gnt"},    32'(bus.m_gnt),    32'd0);
  endtask

  initial begin
    bus.m_req  = 1'b0;
    bus.m_we   = 1'b0;
    bus.m_addr = 16'h0000;
    bus.m_din  = 16'h0000;
    bus.s_ack  = 2'b00;
    bus.s_dout = 32'h0000_0000;

    // Reset values
    tick();
    tick();
    chk("rst_sel",    32'(bus.s_sel),    32'd0);
    chk("rst_we",     32'(bus.s_we),     32'd0);
    chk("rst_addr",   32'(bus.s_addr),   32'd0);
    chk("rst_din",    32'(bus.s_din),    32'd0);
    chk("rst_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("rst_err",    32'(bus.m_err),    32'd0);
    chk("rst_dout",   32'(bus.m_dout),   32'd0);
    rst = 1'b0;
    chk("rst_gnt",    32'(bus.m_gnt),    32'd1);

    // Write to region 1 with three wait cycles
    req(1'b1, 16'h2004, 16'h1234);
    chk("wr_gnt", 32'(bus.m_gnt), 32'd1);
    tick();
    bus.m_req  = 1'b0;
    bus.s_dout = {16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      chk("wr_sel",    32'(bus.s_sel),    32'h2);
      chk("wr_we",     32'(bus.s_we),     32'd1);
      chk("wr_addr",   32'(bus.s_addr),   32'h0004);
      chk("wr_din",    32'(bus.s_din),    32'h1234);
      chk("wr_rvalid", 32'(bus.m_rvalid), 32'd0);
      if (i == 3) bus.s_ack = 2'b10;
      tick();
    end
    bus.s_ack = 2'b00;
    resp_chk("wr", 1'b0, 16'h0000);
    chk("wr_we_drop", 32'(bus.s_we), 32'd0);
    tick();
    chk("wr_idle_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("wr_idle_gnt",    32'(bus.m_gnt),    32'd1);

    // Zero-wait read from region 0
    req(1'b0, 16'h0010, 16'h0000);
    tick();
    bus.m_req = 1'b0;
    chk("rd_sel",  32'(bus.s_sel),  32'h1);
    chk("rd_we",   32'(bus.s_we),   32'd0);
    chk("rd_addr", 32'(bus.s_addr), 32'h0010);
    bus.s_dout = {16'h5A5A, 16'hA5A5};
    bus.s_ack  = 2'b01;
    tick();
    bus.s_ack = 2'b00;
    resp_chk("rd", 1'b0, 16'hA5A5);
    tick();
    chk("rd_rvalid_drop", 32'(bus.m_rvalid), 32'd0);
    chk("rd_dout_hold",   32'(bus.m_dout),   32'hA5A5);

    // Unmapped region 7
    req(1'b1, 16'hE000, 16'hBEEF);
    tick();
    bus.m_req = 1'b0;
    resp_chk("unm", 1'b1, 16'h0000);
    chk("unm_we", 32'(bus.s_we), 32'd0);
    tick();
    chk("unm_rvalid_drop", 32'(bus.m_rvalid), 32'd0);
    chk("unm_gnt",         32'(bus.m_gnt),    32'd1);

    // Ack in the 15th BUSY cycle beats the timeout
    req(1'b0, 16'h0000, 16'h0000);
    tick();
    bus.m_req  = 1'b0;
    bus.s_dout = {16'h0000, 16'h3C3C};
    for (int k = 1; k <= 15; k++) begin
      chk("a15_rvalid", 32'(bus.m_rvalid), 32'd0);
      chk("a15_sel",    32'(bus.s_sel),    32'h1);
      if (k == 15) bus.s_ack = 2'b01;
      tick();
    end
    bus.s_ack = 2'b00;
    resp_chk("a15", 1'b0, 16'h3C3C);
    tick();

    // Silent slave times out after 15 BUSY cycles
    req(1'b0, 16'h0100, 16'h0000);
    tick();
    bus.m_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("tmo_rvalid", 32'(bus.m_rvalid), 32'd0);
      chk("tmo_sel",    32'(bus.s_sel),    32'h1);
      tick();
    end
    resp_chk("tmo", 1'b1, 16'h0000);
    tick();
    chk("tmo_rvalid_drop", 32'(bus.m_rvalid), 32'd0);
    chk("tmo_gnt",         32'(bus.m_gnt),    32'd1);

    // Acks outside BUSY and from the non-selected slave are ignored
    bus.s_ack = 2'b11;
    tick();
    chk("idle_ack_rvalid", 32'(bus.m_rvalid), 32'd0);
    bus.s_ack = 2'b00;
    req(1'b0, 16'h0002, 16'h0000);
    tick();
    bus.m_req  = 1'b0;
    bus.s_dout = {16'hDEAD, 16'h7E7E};
    bus.s_ack  = 2'b10;
    tick();
    chk("stray_rvalid1", 32'(bus.m_rvalid), 32'd0);
    chk("stray_sel",     32'(bus.s_sel),    32'h1);
    tick();
    chk("stray_rvalid2", 32'(bus.m_rvalid), 32'd0);
    bus.s_ack = 2'b01;
    tick();
    bus.s_ack = 2'b00;
    resp_chk("stray", 1'b0, 16'h7E7E);
    tick();

    // Held request is re-accepted on return to IDLE: one access per 3 cycles
    req(1'b0, 16'h0000, 16'h0000);
    bus.s_dout = {16'h0000, 16'h1111};
    tick();
    chk("held_gnt_busy", 32'(bus.m_gnt), 32'd0);
    chk("held_sel_busy", 32'(bus.s_sel), 32'h1);
    bus.s_ack = 2'b01;
    tick();
    bus.s_ack = 2'b00;
    chk("held_rvalid", 32'(bus.m_rvalid), 32'd1);
    chk("held_dout",   32'(bus.m_dout),   32'h1111);
    chk("held_gnt",    32'(bus.m_gnt),    32'd0);
    tick();
    chk("held_gnt_idle", 32'(bus.m_gnt),    32'd1);
    chk("held_sel_idle", 32'(bus.s_sel),    32'd0);
    chk("held_rv_idle",  32'(bus.m_rvalid), 32'd0);
    tick();
    chk("held_sel2", 32'(bus.s_sel), 32'h1);
    chk("held_gnt2", 32'(bus.m_gnt), 32'd0);
    bus.m_req = 1'b0;
    bus.s_ack = 2'b01;
    tick();
    bus.s_ack = 2'b00;
    chk("held_rvalid2", 32'(bus.m_rvalid), 32'd1);
    tick();

    // Reset while BUSY abandons the access with no response
    req(1'b0, 16'h2000, 16'h0000);
    tick();
    bus.m_req = 1'b0;
    chk("mrst_sel_busy", 32'(bus.s_sel), 32'h2);
    rst = 1'b1;
    tick();
    chk("mrst_sel",    32'(bus.s_sel),    32'd0);
    chk("mrst_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("mrst_dout",   32'(bus.m_dout),   32'd0);
    chk("mrst_gnt",    32'(bus.m_gnt),    32'd1);
    rst       = 1'b0;
    bus.s_ack = 2'b10;
    tick();
    bus.s_ack = 2'b00;
    chk("mrst_rvalid2", 32'(bus.m_rvalid), 32'd0);
    chk("mrst_gnt2",    32'(bus.m_gnt),    32'd1);
    tick();
    chk("mrst_rvalid3", 32'(bus.m_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
